rtc_write_sequencer: RTL and testbench

Controller that sequences the BCD write decoder and the RTC write bus: on a start pulse it walks a fixed list of time, date and chronometer fields. For each field it raises the decoder's one-hot select, waits for the registered BCD byte, then hands address and data to the bus write driver over a req/ack handshake. It sits between the adjust-mode control logic and the RTC bus interface.

---
 rtl/rtc_write_sequencer_if.sv | 10 +
 rtl/rtc_write_sequencer.sv | 227 ++++++++++++++++++++++
 tb/tb_rtc_write_sequencer.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rtc_write_sequencer_if.sv
// RTC bus write handshake: sequencer (master) hands address/data to the bus write driver (slave).
interface rtc_write_sequencer_if;
  logic       wr_req;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       wr_ack;

  modport master (output wr_req, output wr_addr, output wr_data, input  wr_ack);
  modport slave  (input  wr_req, input  wr_addr, input  wr_data, output wr_ack);
endinterface

// File: rtl/rtc_write_sequencer.sv
// Walks the time/date/chrono fields: select decoder field, latch BCD byte, write it over req/ack.
// Chronometer fields are present only when CRONO_EN is defined.
module rtc_write_sequencer #(
  parameter int unsigned DECO_LAT = 1,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic [1:0]            i_grp,
  input  logic [7:0]            i_dato_BCD,
  output logic                  o_a_hora,
  output logic                  o_a_min,
  output logic                  o_a_seg,
  output logic                  o_a_dia,
  output logic                  o_a_mes,
  output logic                  o_a_year,
  output logic                  o_a_cr_hora,
  output logic                  o_a_cr_min,
  output logic                  o_a_cr_seg,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err,
  rtc_write_sequencer_if.master wr_bus
);

  localparam int unsigned IDX_W = 4;
  localparam int unsigned LAT_W = 8;
  localparam int unsigned TMO_W = 8;
`ifdef CRONO_EN
  localparam int unsigned NUM_SEL = 9;
`else
  localparam int unsigned NUM_SEL = 6;
`endif

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SEL   = 3'd1,
    ST_REQ   = 3'd2,
    ST_NEXT  = 3'd3,
    ST_DONE  = 3'd4,
    ST_ABORT = 3'd5
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [IDX_W-1:0]   r_idx, w_idx_nxt;
  logic [IDX_W-1:0]   r_last, w_last_nxt;
  logic [IDX_W-1:0]   w_first, w_last;
  logic               w_grp_ok;
  logic [LAT_W-1:0]   r_lat, w_lat_nxt;
  logic [TMO_W-1:0]   r_tmo, w_tmo_nxt;
  logic [NUM_SEL-1:0] r_sel, w_sel_nxt;
  logic               r_req, w_req_nxt;
  logic [7:0]         r_addr, w_addr_nxt;
  logic [7:0]         r_data, w_data_nxt;
  logic               r_busy, w_busy_nxt;
  logic               r_done, w_done_nxt;
  logic               r_err, w_err_nxt;

  function automatic logic [7:0] field_addr(input logic [IDX_W-1:0] idx);
    case (idx)
      4'd0:    return 8'h23;
      4'd1:    return 8'h22;
      4'd2:    return 8'h21;
      4'd3:    return 8'h24;
      4'd4:    return 8'h25;
      4'd5:    return 8'h26;
      4'd6:    return 8'h43;
      4'd7:    return 8'h42;
      4'd8:    return 8'h41;
      default: return 8'h00;
    endcase
  endfunction

  // Field index range of the requested group; grp 2 is invalid without the chronometer.
  always_comb begin
    w_first  = '0;
    w_last   = '0;
    w_grp_ok = 1'b1;
    case (i_grp)
      2'd0: begin w_first = 4'd0; w_last = 4'd2; end
      2'd1: begin w_first = 4'd3; w_last = 4'd5; end
`ifdef CRONO_EN
      2'd2: begin w_first = 4'd6; w_last = 4'd8; end
      default: begin w_first = 4'd0; w_last = 4'd8; end
`else
      2'd2: w_grp_ok = 1'b0;
      default: begin w_first = 4'd0; w_last = 4'd5; end
`endif
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_last_nxt  = r_last;
    w_lat_nxt   = r_lat;
    w_tmo_nxt   = r_tmo;
    w_req_nxt   = 1'b0;
    w_addr_nxt  = r_addr;
    w_data_nxt  = r_data;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    w_sel_nxt   = '0;

    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_busy_nxt = 1'b1;
          if (w_grp_ok) begin
            w_state_nxt = ST_SEL;
            w_idx_nxt   = w_first;
            w_last_nxt  = w_last;
            w_lat_nxt   = '0;
          end else begin
            w_state_nxt = ST_ABORT;
          end
        end
      end
      ST_SEL: begin
        if (r_lat == LAT_W'(DECO_LAT)) begin
          w_state_nxt = ST_REQ;
          w_req_nxt   = 1'b1;
          w_addr_nxt  = field_addr(r_idx);
          w_data_nxt  = i_dato_BCD;
          w_tmo_nxt   = '0;
        end else begin
          w_lat_nxt = r_lat + LAT_W'(1);
        end
      end
      ST_REQ: begin
        if (wr_bus.wr_ack) begin
          w_state_nxt = ST_NEXT;
        end else if (r_tmo == TMO_W'(TIMEOUT - 1)) begin
          w_state_nxt = ST_ABORT;
          w_busy_nxt  = 1'b0;
          w_err_nxt   = 1'b1;
        end else begin
          w_req_nxt = 1'b1;
          w_tmo_nxt = r_tmo + TMO_W'(1);
        end
      end
      ST_NEXT: begin
        if (r_idx == r_last) begin
          w_state_nxt = ST_DONE;
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
        end else begin
          w_state_nxt = ST_SEL;
          w_idx_nxt   = r_idx + IDX_W'(1);
          w_lat_nxt   = '0;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      ST_ABORT: begin
        // Entered from IDLE with busy still set: emit err one cycle later, then leave.
        if (r_busy) begin
          w_busy_nxt = 1'b0;
          w_err_nxt  = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    if ((w_state_nxt == ST_SEL) || (w_state_nxt == ST_REQ)) begin
      w_sel_nxt = NUM_SEL'(1) << w_idx_nxt;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_last  <= '0;
      r_lat   <= '0;
      r_tmo   <= '0;
      r_sel   <= '0;
      r_req   <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_last  <= w_last_nxt;
      r_lat   <= w_lat_nxt;
      r_tmo   <= w_tmo_nxt;
      r_sel   <= w_sel_nxt;
      r_req   <= w_req_nxt;
      r_addr  <= w_addr_nxt;
      r_data  <= w_data_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
    end
  end

  assign o_a_hora = r_sel[0];
  assign o_a_min  = r_sel[1];
  assign o_a_seg  = r_sel[2];
  assign o_a_dia  = r_sel[3];
  assign o_a_mes  = r_sel[4];
  assign o_a_year = r_sel[5];
`ifdef CRONO_EN
  assign o_a_cr_hora = r_sel[6];
  assign o_a_cr_min  = r_sel[7];
  assign o_a_cr_seg  = r_sel[8];
`else
  assign o_a_cr_hora = 1'b0;
  assign o_a_cr_min  = 1'b0;
  assign o_a_cr_seg  = 1'b0;
`endif

  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_err  = r_err;

  assign wr_bus.wr_req  = r_req;
  assign wr_bus.wr_addr = r_addr;
  assign wr_bus.wr_data = r_data;

endmodule

// File: tb/tb_rtc_write_sequencer.sv
// Randomized bench for rtc_write_sequencer: decoder and bus-driver models plus a transaction/timing reference.
module tb_rtc_write_sequencer;

  localparam int DECO_LAT = 1;
`ifdef CRONO_EN
  localparam bit HAS_CRONO = 1'b1;
`else
  localparam bit HAS_CRONO = 1'b0;
`endif

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
    logic [8:0] sel;
  } wr_rec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [1:0] grp;
  logic [7:0] dato_BCD;
  logic a_hora, a_min, a_seg, a_dia, a_mes, a_year, a_cr_hora, a_cr_min, a_cr_seg;
  logic busy, done, err;
  logic [8:0] sel_v;

  rtc_write_sequencer_if bus();

  rtc_write_sequencer #(.DECO_LAT(DECO_LAT), .TIMEOUT(255)) dut (
    .i_clk(clk), .i_reset(reset), .i_start(start), .i_grp(grp), .i_dato_BCD(dato_BCD),
    .o_a_hora(a_hora), .o_a_min(a_min), .o_a_seg(a_seg), .o_a_dia(a_dia), .o_a_mes(a_mes),
    .o_a_year(a_year), .o_a_cr_hora(a_cr_hora), .o_a_cr_min(a_cr_min), .o_a_cr_seg(a_cr_seg),
    .o_busy(busy), .o_done(done), .o_err(err), .wr_bus(bus.master)
  );

  always #5 clk = ~clk;

  assign sel_v = {a_cr_seg, a_cr_min, a_cr_hora, a_year, a_mes, a_dia, a_seg, a_min, a_hora};

  // Field addresses in walk order.
  logic [7:0] field_addr [9] = '{8'h23, 8'h22, 8'h21, 8'h24, 8'h25, 8'h26, 8'h43, 8'h42, 8'h41};
  logic [7:0] fval [9];

  int      n_checks = 0;
  int      n_fail   = 0;
  int      ack_delay = 0;
  bit      ack_never = 1'b0;
  bit      stray_ack = 1'b0;
  int      req_cyc = 0;
  logic [7:0] cap_addr, cap_data;
  logic [8:0] cap_sel;
  wr_rec_t obs_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Write decoder: one register stage from select to byte.
  always @(posedge clk) begin
    logic [7:0] v;
    v = 8'h00;
    for (int i = 0; i < 9; i++) if (sel_v[i]) v = fval[i];
    dato_BCD <= v;
  end

  // Bus write driver: acks after ack_delay extra REQ cycles, records each accepted write.
  always @(negedge clk) begin
    if (bus.wr_req) begin
      if (req_cyc == 0) begin
        cap_addr = bus.wr_addr;
        cap_data = bus.wr_data;
        cap_sel  = sel_v;
      end else begin
        check_eq("req_addr_stable", bus.wr_addr, cap_addr);
        check_eq("req_data_stable", bus.wr_data, cap_data);
        check_eq("req_sel_stable", sel_v, cap_sel);
      end
      req_cyc++;
      if (!ack_never && req_cyc > ack_delay) begin
        bus.wr_ack = 1'b1;
        obs_q.push_back('{addr: bus.wr_addr, data: bus.wr_data, sel: sel_v});
      end else begin
        bus.wr_ack = 1'b0;
      end
    end else begin
      req_cyc = 0;
      bus.wr_ack = stray_ack ? 1'($urandom) : 1'b0;
    end
  end

  function automatic void grp_range(input logic [1:0] g, output int first, output int last);
    if (g == 2'd3) begin
      first = 0;
      last  = HAS_CRONO ? 8 : 5;
    end else begin
      first = 3 * int'(g);
      last  = first + 2;
    end
  endfunction

  task automatic run_seq(input logic [1:0] g, input int d, input bit stray);
    int first, last, n, cnt;
    bit ended;
    logic [8:0] exp_sel;
    for (int i = 0; i < 9; i++) fval[i] = 8'($urandom);
    grp_range(g, first, last);
    n = last - first + 1;
    obs_q.delete();
    ack_delay = d;
    ack_never = 1'b0;
    stray_ack = stray;
    @(negedge clk);
    start = 1'b1;
    grp   = g;
    @(negedge clk);
    start = 1'b0;
    cnt   = 1;
    exp_sel = 9'd1 << first;
    check_eq("busy_rise", busy, 1'b1);
    check_eq("first_sel", sel_v, exp_sel);
    ended = 1'b0;
    while (!ended && cnt < 3000) begin
      if (cnt == 2) check_eq("req_before_lat", bus.wr_req, 1'b0);
      if (cnt == 3) check_eq("req_rise", bus.wr_req, 1'b1);
      if (done || err) begin
        ended = 1'b1;
      end else begin
        if (stray) begin
          start = 1'($urandom);
          grp   = 2'($urandom);
        end
        @(negedge clk);
        cnt++;
      end
    end
    start = 1'b0;
    grp   = g;
    check_eq("seq_end", ended, 1'b1);
    check_eq("done", done, 1'b1);
    check_eq("err_clear", err, 1'b0);
    check_eq("end_cycle", cnt, n * (DECO_LAT + 3 + d) + 1);
    check_eq("busy_fall", busy, 1'b0);
    check_eq("sel_idle", sel_v, 9'd0);
    @(negedge clk);
    check_eq("done_pulse", done, 1'b0);
    check_eq("n_writes", obs_q.size(), n);
    for (int i = 0; i < n && i < obs_q.size(); i++) begin
      exp_sel = 9'd1 << (first + i);
      check_eq("wr_addr", obs_q[i].addr, field_addr[first + i]);
      check_eq("wr_data", obs_q[i].data, fval[first + i]);
      check_eq("wr_sel", obs_q[i].sel, exp_sel);
    end
    stray_ack = 1'b0;
  endtask

  task automatic abort_grp2();
    obs_q.delete();
    @(negedge clk);
    start = 1'b1;
    grp   = 2'd2;
    @(negedge clk);
    check_eq("g2_busy", busy, 1'b1);
    check_eq("g2_sel", sel_v, 9'd0);
    check_eq("g2_req", bus.wr_req, 1'b0);
    check_eq("g2_err_early", err, 1'b0);
    @(negedge clk);
    start = 1'b0;
    check_eq("g2_err", err, 1'b1);
    check_eq("g2_busy_fall", busy, 1'b0);
    @(negedge clk);
    check_eq("g2_err_pulse", err, 1'b0);
    check_eq("g2_idle", busy, 1'b0);
    check_eq("g2_writes", obs_q.size(), 0);
  endtask

  task automatic timeout_test();
    int n, reqc;
    obs_q.delete();
    ack_never = 1'b1;
    @(negedge clk);
    start = 1'b1;
    grp   = 2'd0;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!bus.wr_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq("tmo_req_seen", bus.wr_req, 1'b1);
    n = 1;
    reqc = 1;
    while (!err && n < 400) begin
      @(negedge clk);
      n++;
      if (bus.wr_req) reqc++;
    end
    check_eq("tmo_err_cycle", n, 256);
    check_eq("tmo_req_cycles", reqc, 255);
    check_eq("tmo_busy", busy, 1'b0);
    check_eq("tmo_sel", sel_v, 9'd0);
    @(negedge clk);
    check_eq("tmo_err_pulse", err, 1'b0);
    check_eq("tmo_writes", obs_q.size(), 0);
    ack_never = 1'b0;
  endtask

  task automatic reset_mid_req();
    int n;
    ack_delay = 6;
    ack_never = 1'b0;
    @(negedge clk);
    start = 1'b1;
    grp   = 2'd0;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!(bus.wr_req && sel_v == 9'd2) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq("rst_reach_field2", bus.wr_req && sel_v == 9'd2, 1'b1);
    #2 reset = 1'b0;
    #1;
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_done", done, 1'b0);
    check_eq("rst_err", err, 1'b0);
    check_eq("rst_req", bus.wr_req, 1'b0);
    check_eq("rst_addr", bus.wr_addr, 8'h00);
    check_eq("rst_data", bus.wr_data, 8'h00);
    check_eq("rst_sel", sel_v, 9'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_eq("rst_after_release", busy | done | err, 1'b0);
    run_seq(2'd1, 2, 1'b0);
  endtask

  initial begin
    logic [1:0] g;
    reset = 1'b0;
    start = 1'b0;
    grp   = 2'd0;
    for (int i = 0; i < 9; i++) fval[i] = 8'h00;
    repeat (3) @(negedge clk);
    check_eq("init_busy", busy, 1'b0);
    check_eq("init_done", done, 1'b0);
    check_eq("init_err", err, 1'b0);
    check_eq("init_req", bus.wr_req, 1'b0);
    check_eq("init_addr", bus.wr_addr, 8'h00);
    check_eq("init_data", bus.wr_data, 8'h00);
    check_eq("init_sel", sel_v, 9'd0);
    reset = 1'b1;
    @(negedge clk);

    run_seq(2'd0, 1, 1'b0);
    run_seq(2'd3, 0, 1'b0);
    run_seq(2'd1, 10, 1'b0);
`ifdef CRONO_EN
    run_seq(2'd2, 3, 1'b0);
`else
    abort_grp2();
`endif
    run_seq(2'd3, 2, 1'b1);
    for (int k = 0; k < 4; k++) begin
      g = 2'($urandom_range(0, 3));
      if (!HAS_CRONO && g == 2'd2) g = 2'd3;
      run_seq(g, int'($urandom_range(0, 4)), 1'($urandom));
    end
    timeout_test();
    reset_mid_req();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
